// File: rtl/axis_output_pipe_if.sv
// AXI-Stream bundle used on both the wide input side and the narrow output side
// of axis_output_pipe.
interface axis_output_pipe_if #(
    parameter int DATA_WIDTH = 128
);
    logic                    tvalid;
    logic                    tready;
    logic                    tlast;
    logic                    tuser;
    logic [DATA_WIDTH-1:0]   tdata;
    logic [DATA_WIDTH/8-1:0] tkeep;

    modport master (output tvalid, tlast, tuser, tdata, tkeep, input tready);
    modport slave  (input tvalid, tlast, tuser, tdata, tkeep, output tready);
endinterface

// File: rtl/axis_output_pipe.sv
// Conv-engine result serializer: drops partial-sum beats and splits each final
// wide beat into BEATS narrow AXI-Stream beats. OUTPUT_PIPE_SKID_EN adds a 2-entry output slice.
module axis_output_pipe #(
    parameter int WORD_WIDTH_ACC = 32,
    parameter int UNITS          = 8,
    parameter int CORES          = 4,
    parameter int COPIES         = 2,
    parameter int M_DATA_WORDS   = 4
) (
    input  logic               aclk,
    input  logic               areset,
    axis_output_pipe_if.slave  s_axis,
    axis_output_pipe_if.master m_axis
);
    localparam int N     = COPIES * CORES * UNITS;
    localparam int MW    = M_DATA_WORDS * WORD_WIDTH_ACC;
    localparam int BEATS = N / M_DATA_WORDS;
    localparam int KW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(BEATS - 1);
    localparam logic [KW-1:0] K_ONE  = KW'(1);
    localparam logic [KW-1:0] K_ZERO = KW'(0);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    generate
        if ((N % M_DATA_WORDS) != 0) begin : g_bad_split
            $error("axis_output_pipe: N must be a multiple of M_DATA_WORDS");
        end
    endgenerate

    state_t                     state_r;
    state_t                     state_nxt_s;
    logic [KW-1:0]              k_r;
    logic                       last_q_r;
    logic [BEATS-1:0][MW-1:0]   hold_r;

    logic                       s_ready_s;
    logic                       cap_s;
    logic                       final_s;
    logic                       core_valid_s;
    logic                       core_ready_s;
    logic                       core_fire_s;
    logic                       core_last_s;
    logic [MW-1:0]              core_data_s;
    logic                       unused_s;

    assign final_s     = (k_r == K_LAST);
    assign cap_s       = s_axis.tvalid && s_ready_s && s_axis.tuser;
    assign core_fire_s = core_valid_s && core_ready_s;
    assign unused_s    = ^s_axis.tkeep;

    // State register.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; a final beat handshake may reload directly for a bubble-free stream.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (cap_s) begin
                    state_nxt_s = SEND;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            SEND: begin
                if (core_fire_s && final_s && !cap_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = SEND;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // FSM outputs; input side only opens in SEND while the last narrow beat is leaving.
    always_comb begin
        s_ready_s    = 1'b0;
        core_valid_s = 1'b0;
        case (state_r)
            IDLE: begin
                s_ready_s    = !areset;
                core_valid_s = 1'b0;
            end
            SEND: begin
                s_ready_s    = !areset && final_s && core_ready_s;
                core_valid_s = 1'b1;
            end
            default: begin
                s_ready_s    = 1'b0;
                core_valid_s = 1'b0;
            end
        endcase
    end

    // Beat counter and packet-last flag.
    always_ff @(posedge aclk) begin
        if (areset) begin
            k_r      <= K_ZERO;
            last_q_r <= 1'b0;
        end else if (cap_s) begin
            k_r      <= K_ZERO;
            last_q_r <= s_axis.tlast;
        end else if (core_fire_s) begin
            k_r      <= final_s ? K_ZERO : (k_r + K_ONE);
            last_q_r <= last_q_r;
        end else begin
            k_r      <= k_r;
            last_q_r <= last_q_r;
        end
    end

    // Holding register, written only on a captured final beat.
    always_ff @(posedge aclk) begin
        if (cap_s) begin
            hold_r <= s_axis.tdata;
        end else begin
            hold_r <= hold_r;
        end
    end

    // Narrow beat select; forced to zero outside SEND so idle outputs read as zero.
    always_comb begin
        core_data_s = {MW{1'b0}};
        core_last_s = 1'b0;
        if (core_valid_s) begin
            core_data_s = hold_r[k_r];
            core_last_s = last_q_r && final_s;
        end else begin
            core_data_s = {MW{1'b0}};
            core_last_s = 1'b0;
        end
    end

`ifdef OUTPUT_PIPE_SKID_EN
    logic          out_valid_r;
    logic          out_last_r;
    logic [MW-1:0] out_data_r;
    logic          sk_valid_r;
    logic          sk_last_r;
    logic [MW-1:0] sk_data_r;

    assign core_ready_s = !sk_valid_r;

    // Output stage plus one skid entry that catches the beat accepted while the output stalls.
    always_ff @(posedge aclk) begin
        if (areset) begin
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
            out_data_r  <= {MW{1'b0}};
            sk_valid_r  <= 1'b0;
            sk_last_r   <= 1'b0;
            sk_data_r   <= {MW{1'b0}};
        end else if (!out_valid_r || m_axis.tready) begin
            if (sk_valid_r) begin
                out_valid_r <= 1'b1;
                out_last_r  <= sk_last_r;
                out_data_r  <= sk_data_r;
                sk_valid_r  <= 1'b0;
            end else begin
                out_valid_r <= core_valid_s;
                out_last_r  <= core_last_s;
                out_data_r  <= core_data_s;
            end
        end else if (core_fire_s) begin
            sk_valid_r <= 1'b1;
            sk_last_r  <= core_last_s;
            sk_data_r  <= core_data_s;
        end else begin
            sk_valid_r <= sk_valid_r;
        end
    end

    assign m_axis.tvalid = out_valid_r;
    assign m_axis.tlast  = out_last_r;
    assign m_axis.tdata  = out_data_r;
`else
    assign core_ready_s  = m_axis.tready;
    assign m_axis.tvalid = core_valid_s;
    assign m_axis.tlast  = core_last_s;
    assign m_axis.tdata  = core_data_s;
`endif

    assign m_axis.tkeep  = {(MW/8){1'b1}};
    assign m_axis.tuser  = 1'b1;
    assign s_axis.tready = s_ready_s;

endmodule
